// File: rtl/voice_mixer_env.sv
// N-voice time-multiplexed mixer with per-voice gain, optional linear attack/release envelope and output saturation.
// Define MIXER_ENVELOPE_EN to enable the envelope; otherwise each voice is hard-gated by ch_gate at the accepted tick.
module voice_mixer_env #(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_W     = 16,
  parameter int GAIN_W       = 8,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_tick,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_samples,
  input  logic [NUM_CH*GAIN_W-1:0]     ch_gain,
  input  logic [NUM_CH-1:0]            ch_gate,
  input  logic [1:0]                   master_shift,
  output logic [SAMPLE_W-1:0]          mix_out,
  output logic                         mix_valid,
  output logic                         clip,
  output logic                         busy,
  output logic                         overrun
);

  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W   = SAMPLE_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam int PROD_W  = SAMPLE_W + GAIN_W + 1;
  localparam int ENV_MAX = (1 << GAIN_W) - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  function automatic logic [GAIN_W-1:0] env_next(input logic [GAIN_W-1:0] env, input logic gate);
    int v;
    v = gate ? ((int'(env) + ATTACK_STEP > ENV_MAX) ? ENV_MAX : int'(env) + ATTACK_STEP)
             : ((int'(env) - RELEASE_STEP < 0) ? 0 : int'(env) - RELEASE_STEP);
    return GAIN_W'(v);
  endfunction

  // Returns {clip, saturated sample}.
  function automatic logic [SAMPLE_W:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return {1'b1, SAT_MAX[SAMPLE_W-1:0]};
    end else if (v < SAT_MIN) begin
      return {1'b1, SAT_MIN[SAMPLE_W-1:0]};
    end else begin
      return {1'b0, v[SAMPLE_W-1:0]};
    end
  endfunction

  logic [1:0]                          state_r;
  logic [IDX_W-1:0]                    idx_r;
  logic signed [ACC_W-1:0]             acc_r;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]     samp_r;
  logic [NUM_CH-1:0][GAIN_W-1:0]       gain_r;
  logic [1:0]                          shift_r;
  logic [SAMPLE_W-1:0]                 mix_out_r;
  logic                                mix_valid_r;
  logic                                clip_r;
  logic                                overrun_r;
`ifdef MIXER_ENVELOPE_EN
  logic [NUM_CH-1:0][GAIN_W-1:0]       env_r;
  logic [2*GAIN_W:0]                   gprod_s;
`endif

  logic [GAIN_W-1:0]                   g_s;
  logic signed [PROD_W-1:0]            prod_s;
  logic signed [ACC_W-1:0]             acc_next_s;
  logic [5:0]                          shamt_s;
  logic signed [ACC_W-1:0]             shifted_s;
  logic [SAMPLE_W:0]                   sat_s;

  // Effective gain and product for the voice selected by idx, plus the output scaling.
  always_comb begin
`ifdef MIXER_ENVELOPE_EN
    gprod_s = (2*GAIN_W+1)'(gain_r[idx_r]) * ((2*GAIN_W+1)'(env_r[idx_r]) + (2*GAIN_W+1)'(1));
    g_s     = GAIN_W'(gprod_s >> GAIN_W);
`else
    g_s     = gain_r[idx_r];
`endif
    prod_s     = PROD_W'($signed(samp_r[idx_r])) * PROD_W'($signed({1'b0, g_s}));
    acc_next_s = acc_r + ACC_W'(prod_s);
    shamt_s    = 6'(GAIN_W) + {4'd0, shift_r};
    shifted_s  = acc_r >>> shamt_s;
    sat_s      = saturate(shifted_s);
  end

  // Frame sequencer: snapshot on accepted tick, one MAC per clock, then saturate and publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      acc_r       <= '0;
      samp_r      <= '0;
      gain_r      <= '0;
      shift_r     <= 2'd0;
      mix_out_r   <= '0;
      mix_valid_r <= 1'b0;
      clip_r      <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef MIXER_ENVELOPE_EN
      env_r       <= '0;
`endif
    end else begin
      mix_valid_r <= 1'b0;
      if (sample_tick && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (sample_tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
              samp_r[i] <= ch_samples[i*SAMPLE_W +: SAMPLE_W];
`ifdef MIXER_ENVELOPE_EN
              gain_r[i] <= ch_gain[i*GAIN_W +: GAIN_W];
              env_r[i]  <= env_next(env_r[i], ch_gate[i]);
`else
              gain_r[i] <= ch_gate[i] ? ch_gain[i*GAIN_W +: GAIN_W] : {GAIN_W{1'b0}};
`endif
            end
            shift_r <= master_shift;
            acc_r   <= '0;
            idx_r   <= '0;
            state_r <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_r <= acc_next_s;
          if (idx_r == IDX_W'(NUM_CH - 1)) begin
            state_r <= ST_OUT;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_OUT: begin
          mix_out_r   <= sat_s[SAMPLE_W-1:0];
          clip_r      <= sat_s[SAMPLE_W];
          mix_valid_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign mix_out   = mix_out_r;
  assign mix_valid = mix_valid_r;
  assign clip      = clip_r;
  assign busy      = (state_r != ST_IDLE);
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_voice_mixer_env.sv
// Self-checking bench for voice_mixer_env: two instances (attack 255 and default steps) checked every cycle
// against a frame-level arithmetic model, plus hand-computed expectations; honours MIXER_ENVELOPE_EN.
module tb_voice_mixer_env;
  localparam int NC = 4;
  localparam int SW = 16;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic [NC*SW-1:0] ch_samples = '0;
  logic [NC*GW-1:0] ch_gain = '0;
  logic [NC-1:0]    ch_gate = '0;
  logic [1:0]       master_shift = 2'd0;

  logic [SW-1:0] mix_out_a, mix_out_b;
  logic mix_valid_a, mix_valid_b, clip_a, clip_b, busy_a, busy_b, overrun_a, overrun_b;

  always #5 clk = ~clk;

  voice_mixer_env #(.NUM_CH(NC), .SAMPLE_W(SW), .GAIN_W(GW), .ATTACK_STEP(255), .RELEASE_STEP(2)) dut_a (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .ch_samples(ch_samples), .ch_gain(ch_gain),
    .ch_gate(ch_gate), .master_shift(master_shift), .mix_out(mix_out_a), .mix_valid(mix_valid_a),
    .clip(clip_a), .busy(busy_a), .overrun(overrun_a));

  voice_mixer_env #(.NUM_CH(NC), .SAMPLE_W(SW), .GAIN_W(GW), .ATTACK_STEP(4), .RELEASE_STEP(2)) dut_b (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .ch_samples(ch_samples), .ch_gain(ch_gain),
    .ch_gate(ch_gate), .master_shift(master_shift), .mix_out(mix_out_b), .mix_valid(mix_valid_b),
    .clip(clip_b), .busy(busy_b), .overrun(overrun_b));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Frame-level model: per instance, envelope array, frame countdown, pending and published results.
  int     att_m[2] = '{255, 4};
  int     env_m[2][NC];
  int     left_m[2];
  longint pend_out[2];
  bit     pend_clip[2];
  longint exp_out[2];
  bit     exp_clip[2], exp_valid[2], exp_over[2];
  longint sum_m, r_m;
  int     smp_m, gain_m, g_m;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < NC; i++) env_m[d][i] = 0;
        left_m[d] = 0; exp_out[d] = 0; exp_clip[d] = 0; exp_valid[d] = 0; exp_over[d] = 0;
      end else begin
        exp_valid[d] = 0;
        if (left_m[d] > 0) begin
          if (sample_tick) exp_over[d] = 1;
          left_m[d]--;
          if (left_m[d] == 0) begin
            exp_valid[d] = 1;
            exp_out[d]   = pend_out[d];
            exp_clip[d]  = pend_clip[d];
          end
        end else if (sample_tick) begin
          sum_m = 0;
          for (int i = 0; i < NC; i++) begin
            smp_m  = int'($signed(ch_samples[i*SW +: SW]));
            gain_m = int'(ch_gain[i*GW +: GW]);
`ifdef MIXER_ENVELOPE_EN
            if (ch_gate[i]) env_m[d][i] = (env_m[d][i] + att_m[d] > 255) ? 255 : env_m[d][i] + att_m[d];
            else            env_m[d][i] = (env_m[d][i] - 2 < 0) ? 0 : env_m[d][i] - 2;
            g_m = (gain_m * (env_m[d][i] + 1)) / 256;
`else
            g_m = ch_gate[i] ? gain_m : 0;
`endif
            sum_m += longint'(smp_m) * longint'(g_m);
          end
          r_m = sum_m >>> (8 + int'(master_shift));
          pend_clip[d] = (r_m > 32767) || (r_m < -32768);
          pend_out[d]  = (r_m > 32767) ? 32767 : ((r_m < -32768) ? -32768 : r_m);
          left_m[d]    = NC + 1;
        end
      end
    end
  end

  task automatic cmp(input string tag, input int d, input logic [SW-1:0] mo, input logic v,
                     input logic c, input logic b, input logic o);
    chk({tag, "_mix_out"}, longint'($signed(mo)), exp_out[d]);
    chk({tag, "_mix_valid"}, longint'(v), longint'(exp_valid[d]));
    chk({tag, "_clip"}, longint'(c), longint'(exp_clip[d]));
    chk({tag, "_busy"}, longint'(b), longint'(left_m[d] > 0));
    chk({tag, "_overrun"}, longint'(o), longint'(exp_over[d]));
  endtask

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a", 0, mix_out_a, mix_valid_a, clip_a, busy_a, overrun_a);
      cmp("b", 1, mix_out_b, mix_valid_b, clip_b, busy_b, overrun_b);
    end
  end

  task automatic set_ch(input int i, input int smp, input int gain, input bit gate);
    ch_samples[i*SW +: SW] = SW'(smp);
    ch_gain[i*GW +: GW]    = GW'(gain);
    ch_gate[i]             = gate;
  endtask

  task automatic clear_ch();
    ch_samples = '0; ch_gain = '0; ch_gate = '0; master_shift = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Tick accepted at the next edge; returns at the negedge right after mix_valid should rise.
  task automatic frame();
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    repeat (NC + 1) @(negedge clk);
  endtask

  int npulse;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // Idle after reset
    repeat (100) @(negedge clk);
    chk("t1_busy", longint'(busy_a), 0);
    chk("t1_out", longint'($signed(mix_out_a)), 0);
    chk("t1_valid", longint'(mix_valid_b), 0);

    // Single voice, then extra master shift
    clear_ch(); set_ch(0, 1000, 128, 1'b1);
    frame();
    chk("t2_valid", longint'(mix_valid_a), 1);
    chk("t2_out", longint'($signed(mix_out_a)), 500);
    chk("t2_clip", longint'(clip_a), 0);
    master_shift = 2'd2;
    frame();
    chk("t2_shift_out", longint'($signed(mix_out_a)), 125);

    // Saturation both ways
    clear_ch();
    for (int i = 0; i < NC; i++) set_ch(i, 32767, 255, 1'b1);
    frame();
    chk("t3_pos_out", longint'($signed(mix_out_a)), 32767);
    chk("t3_pos_clip", longint'(clip_a), 1);
    for (int i = 0; i < NC; i++) set_ch(i, -32768, 255, 1'b1);
    frame();
    chk("t3_neg_out", longint'($signed(mix_out_a)), -32768);
    chk("t3_neg_clip", longint'(clip_a), 1);

    // Envelope ramp on default-step instance
    do_reset();
    clear_ch(); set_ch(0, 1000, 255, 1'b1);
    repeat (3) frame();
`ifdef MIXER_ENVELOPE_EN
    chk("t4_attack_out", longint'($signed(mix_out_b)), 46);
`else
    chk("t4_attack_out", longint'($signed(mix_out_b)), 996);
`endif
    ch_gate[0] = 1'b0;
    frame();
`ifdef MIXER_ENVELOPE_EN
    chk("t4_release_out", longint'($signed(mix_out_b)), 39);
`else
    chk("t4_release_out", longint'($signed(mix_out_b)), 0);
`endif

    // Tick while busy
    do_reset();
    clear_ch(); set_ch(0, 1000, 128, 1'b1);
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    npulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (mix_valid_a) npulse++;
    end
    chk("t5_pulses", npulse, 1);
    chk("t5_overrun_a", longint'(overrun_a), 1);
    chk("t5_overrun_b", longint'(overrun_b), 1);
    do_reset();
    chk("t5_overrun_clr", longint'(overrun_a), 0);

    // Reset mid-frame
    clear_ch(); set_ch(0, 1000, 255, 1'b1);
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    npulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (mix_valid_b) npulse++;
    end
    chk("t6_pulses", npulse, 0);
    chk("t6_out", longint'($signed(mix_out_b)), 0);
    frame();
`ifdef MIXER_ENVELOPE_EN
    chk("t6_env_restart", longint'($signed(mix_out_b)), 15);
`else
    chk("t6_env_restart", longint'($signed(mix_out_b)), 996);
    clear_ch(); set_ch(0, 1000, 128, 1'b0);
    frame();
    chk("t6_hard_gate", longint'($signed(mix_out_a)), 0);
`endif

    // Randomised traffic, inputs changing every cycle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        set_ch(i, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
      end
      master_shift = 2'($urandom_range(0, 3));
      sample_tick  = ($urandom_range(0, 3) == 0);
      rst          = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk) begin sample_tick = 1'b0; rst = 1'b0; end
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
